decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised successor to the single-cycle instruction decoder. It accepts one instruction per cycle over a valid/ready handshake and splits it into register indices and an immediate. It adds an immediate-extension prefix instruction and a flush input. It sits between fetch and the register-file read / execute stage, giving one cycle of decode latency.

## Interface
- `IW`, default 9: instruction width; opcode-class bits are always `instr[IW-1 -: 5]`.
- `RW`, default 4: register index width; indices are zero-extended into it.
- `IMMW`, default 8: immediate width; must be at least 8. Extension field width is `EXTW = IMMW-4`.
- `LDI_BASE`, default `'h40`: OR-base for the ldi/sti immediate when no prefix is pending.

- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: `instr` is valid.
- `in_ready`, output, 1: stage can accept an instruction.
- `instr`, input, `IW`: instruction word.
- `flush`, input, 1: discard the held output and any pending prefix.
- `out_valid`, output, 1: decoded fields are valid.
- `out_ready`, input, 1: downstream accepts this cycle.
- `reg0`, `reg1`, output, `RW`: register indices.
- `imm`, output, `IMMW`: immediate.
- `use_imm`, output, 1: downstream selects `imm` over `reg1`.
- `illegal`, output, 1: unrecognised opcode. Fields are 0 when set.
- `instr_q`, output, `IW`: registered raw instruction, passed through.

## Operation
Bit positions below are for `IW`=9. Upper class bits are `instr[8:4]`. Unused outputs are 0.
- **`00xxx`**: `reg0=instr[5:3]`, `reg1=instr[2:0]`.
- **`01xxx`**: `reg0=instr[3:2]`, `reg1=instr[1:0]`.
- **`1000x` / `10010` (jumps)**: `imm={ext, instr[3:0]}`, `use_imm=1`.
- **`1010x` / `10110` / `10111`**: `reg0=instr[2:0]`, `reg1=0`.
- **`11000` (ldi/sti)**: `use_imm=1`.
  - Prefix pending: `imm={ext, instr[3:0]}`.
  - No prefix: `imm=LDI_BASE | instr[3:0]`.
- **`11001` (EXT prefix, new)**: no output is produced.
  - On accept: `ext_q <= {0, instr[3:0]}` sized to `EXTW`, and `ext_pend <= 1`.
  - `ext` is `ext_q` when `ext_pend`, else 0.
- **Anything else**: `illegal=1`, emitted as a normal output.
- **Prefix lifetime**: `ext_pend` clears on acceptance of any non-prefix instruction, whether or not it uses an immediate.
- **Back-to-back prefixes**: a second prefix overwrites `ext_q`. There is no accumulation.

## Timing
- **Reset values**: `out_valid=0`, `ext_pend=0`, `ext_q=0`; all field outputs and `instr_q` are 0.
- **Handshake**:
  - `in_ready = !out_valid | out_ready`, combinational.
  - Accept occurs when `in_valid & in_ready`.
  - A non-prefix accept loads the output register on that edge, so `out_valid=1` the next cycle (latency 1).
- **Accepting a prefix**: `out_valid` becomes `out_valid & !out_ready` (the held output may still drain). No new output is produced.
- **Stall**: while `out_valid & !out_ready`, all outputs hold stable.
- **Flush has priority over everything**: on a flush edge, `out_valid <= 0`, `ext_pend <= 0`, and any same-cycle accept is dropped. `in_ready` is unaffected by `flush`.
- **Simultaneous drain and accept**: new data replaces old with no bubble.
- **Reset mid-operation**: returns immediately to reset values; a pending prefix is lost.

## Structure
- **`decode_pkg`** holds:
  - the `instr_class_e` enum: RR3, RR2, JMP, R1, LDI, EXT, ILL;
  - the 5-bit class pattern constants;
  - the `decoded_t` struct (reg0, reg1, imm, use_imm, illegal).
- **`instr_classify`** is a combinational sub-module: `instr` plus `ext`/`ext_pend` in, `decoded_t` and class out.
- **`decode_stage`** holds the output register, the prefix state, and the handshake logic.

## Test plan
- **Reset**: assert `rst_n=0` mid-stream → all outputs 0 asynchronously; `in_ready=1` after release.
- **RR3 decode**: `9'h02B` accepted with `out_ready=1` → next cycle `out_valid=1`, `reg0=5`, `reg1=3`, `use_imm=0`.
- **ldi without/with prefix**:
  - `9'h185` → `imm=8'h45`, `use_imm=1`.
  - `9'h193` then `9'h185` → one output only, `imm=8'h35`.
  - A following `9'h185` → `imm=8'h45` again.
- **Prefix then jump**: `9'h193`, `9'h12A` → single output `imm=8'h3A`; a prefix followed by `9'h02B` clears the prefix.
- **Backpressure**: `out_ready=0` for 3 cycles with `in_valid=1` → outputs stable, `in_ready=0`. When `out_ready` rises, the next instruction appears the following cycle with no loss.
- **Flush and illegal**:
  - `flush` in the same cycle as an accept with a prefix pending → `out_valid=0` next cycle; the next ldi gives `8'h4x`.
  - `9'h1F0` → `illegal=1`, `reg0=reg1=imm=0`.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg
//   Shared types for the registered instruction decode stage: the instruction
//   class enum, the 5-bit class match patterns (value/mask pairs) with a helper
//   that maps class bits to a class, and the decoded_t field bundle.
//   decoded_t fields are sized to generous maxima so the struct can live in
//   the package; users zero-extend into it and slice their own widths back out.
package decode_pkg;

  localparam int CLS_W    = 5;
  localparam int MAX_RW   = 16;
  localparam int MAX_IMMW = 32;

  typedef enum logic [2:0] {
    RR3,
    RR2,
    JMP,
    R1,
    LDI,
    EXT,
    ILL
  } instr_class_e;

  // Class patterns: a class matches when (bits & MSK) == PAT.
  localparam logic [CLS_W-1:0] PAT_RR3  = 5'b00000;
  localparam logic [CLS_W-1:0] MSK_RR3  = 5'b11000;
  localparam logic [CLS_W-1:0] PAT_RR2  = 5'b01000;
  localparam logic [CLS_W-1:0] MSK_RR2  = 5'b11000;
  localparam logic [CLS_W-1:0] PAT_JMPA = 5'b10000;
  localparam logic [CLS_W-1:0] MSK_JMPA = 5'b11110;
  localparam logic [CLS_W-1:0] PAT_JMPB = 5'b10010;
  localparam logic [CLS_W-1:0] PAT_R1   = 5'b10100;
  localparam logic [CLS_W-1:0] MSK_R1   = 5'b11100;
  localparam logic [CLS_W-1:0] PAT_LDI  = 5'b11000;
  localparam logic [CLS_W-1:0] PAT_EXT  = 5'b11001;

  typedef struct packed {
    logic [MAX_RW-1:0]   reg0;
    logic [MAX_RW-1:0]   reg1;
    logic [MAX_IMMW-1:0] imm;
    logic                use_imm;
    logic                illegal;
  } decoded_t;

  function automatic instr_class_e classify_bits(input logic [CLS_W-1:0] c);
    instr_class_e cls;
    cls = ILL;
    if ((c & MSK_RR3) == PAT_RR3)                   cls = RR3;
    else if ((c & MSK_RR2) == PAT_RR2)              cls = RR2;
    else if (((c & MSK_JMPA) == PAT_JMPA) ||
             (c == PAT_JMPB))                       cls = JMP;
    else if ((c & MSK_R1) == PAT_R1)                cls = R1;
    else if (c == PAT_LDI)                          cls = LDI;
    else if (c == PAT_EXT)                          cls = EXT;
    return cls;
  endfunction

endpackage

// File: rtl/decode_if.sv
// decode_if
//   Bundles the fetch-side handshake, the flush request and the decoded
//   output bus of decode_stage.
//   master : fetch/downstream side (drives in_valid, instr, flush, out_ready)
//   slave  : decode_stage side (drives in_ready, out_valid and all fields)
interface decode_if #(
  parameter int IW   = 9,
  parameter int RW   = 4,
  parameter int IMMW = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [IW-1:0]   instr;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [RW-1:0]   reg0;
  logic [RW-1:0]   reg1;
  logic [IMMW-1:0] imm;
  logic            use_imm;
  logic            illegal;
  logic [IW-1:0]   instr_q;

  modport master (
    output in_valid, instr, flush, out_ready,
    input  in_ready, out_valid, reg0, reg1, imm, use_imm, illegal, instr_q
  );

  modport slave (
    input  in_valid, instr, flush, out_ready,
    output in_ready, out_valid, reg0, reg1, imm, use_imm, illegal, instr_q
  );
endinterface

// File: rtl/instr_classify.sv
// instr_classify
//   Combinational decode of one instruction word into register indices and
//   an immediate, given the current prefix extension state.
//   i_instr    : instruction word (class bits are i_instr[IW-1 -: 5])
//   i_ext      : stored prefix extension field
//   i_ext_pend : a prefix is pending; otherwise the extension reads as 0
//   o_dec      : decoded fields (zero-extended into decoded_t)
//   o_class    : instruction class
module instr_classify
  import decode_pkg::*;
#(
  parameter int              IW       = 9,
  parameter int              RW       = 4,
  parameter int              IMMW     = 8,
  parameter logic [IMMW-1:0] LDI_BASE = 'h40,
  localparam int             EXTW     = IMMW - 4
) (
  input  logic [IW-1:0]   i_instr,
  input  logic [EXTW-1:0] i_ext,
  input  logic            i_ext_pend,
  output decoded_t        o_dec,
  output instr_class_e    o_class
);

  instr_class_e    w_class;
  logic [EXTW-1:0] w_ext;
  logic [IMMW-1:0] w_ext_imm;
  logic [IMMW-1:0] w_ldi_imm;

  assign w_class   = classify_bits(i_instr[IW-1 -: CLS_W]);
  assign w_ext     = i_ext_pend ? i_ext : '0;
  assign w_ext_imm = {w_ext, i_instr[3:0]};
  assign w_ldi_imm = LDI_BASE | IMMW'(i_instr[3:0]);
  assign o_class   = w_class;

  always_comb begin
    o_dec = '0;
    unique case (w_class)
      RR3: begin
        o_dec.reg0 = MAX_RW'(i_instr[5:3]);
        o_dec.reg1 = MAX_RW'(i_instr[2:0]);
      end
      RR2: begin
        o_dec.reg0 = MAX_RW'(i_instr[3:2]);
        o_dec.reg1 = MAX_RW'(i_instr[1:0]);
      end
      JMP: begin
        o_dec.imm     = MAX_IMMW'(w_ext_imm);
        o_dec.use_imm = 1'b1;
      end
      R1: begin
        o_dec.reg0 = MAX_RW'(i_instr[2:0]);
      end
      LDI: begin
        // A pending prefix replaces the fixed base entirely.
        o_dec.imm     = MAX_IMMW'(i_ext_pend ? w_ext_imm : w_ldi_imm);
        o_dec.use_imm = 1'b1;
      end
      EXT: begin
        // Prefix carries no output fields.
      end
      default: begin
        o_dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage
//   One-cycle registered instruction decoder between fetch and register read.
//   Accepts an instruction per cycle over valid/ready, holds decoded fields in
//   an output register, and keeps the state of the immediate-extension prefix.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : decode_if.slave
//     in_valid/in_ready/instr   : instruction input handshake
//     flush                     : drop held output and any pending prefix
//     out_valid/out_ready       : decoded output handshake
//     reg0/reg1/imm/use_imm/illegal/instr_q : decoded fields and raw word
module decode_stage
  import decode_pkg::*;
#(
  parameter int              IW       = 9,
  parameter int              RW       = 4,
  parameter int              IMMW     = 8,
  parameter logic [IMMW-1:0] LDI_BASE = 'h40,
  localparam int             EXTW     = IMMW - 4
) (
  input  logic    clk,
  input  logic    rst_n,
  decode_if.slave bus
);

  decoded_t        w_dec;
  instr_class_e    w_class;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_is_ext;
  logic            w_unused_dec;

  logic            r_vld_p1;
  logic [RW-1:0]   r_reg0_p1;
  logic [RW-1:0]   r_reg1_p1;
  logic [IMMW-1:0] r_imm_p1;
  logic            r_use_imm_p1;
  logic            r_illegal_p1;
  logic [IW-1:0]   r_instr_p1;
  logic            r_ext_pend;
  logic [EXTW-1:0] r_ext_q;

  instr_classify #(
    .IW       (IW),
    .RW       (RW),
    .IMMW     (IMMW),
    .LDI_BASE (LDI_BASE)
  ) u_classify (
    .i_instr    (bus.instr),
    .i_ext      (r_ext_q),
    .i_ext_pend (r_ext_pend),
    .o_dec      (w_dec),
    .o_class    (w_class)
  );

  // Upper bits of the package-wide struct beyond RW/IMMW are always zero.
  assign w_unused_dec = ^w_dec;

  assign w_in_ready = !r_vld_p1 || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_ext   = (w_class == EXT);

  // ---- stage p0 -> p1: decode register and prefix state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1     <= 1'b0;
      r_reg0_p1    <= '0;
      r_reg1_p1    <= '0;
      r_imm_p1     <= '0;
      r_use_imm_p1 <= 1'b0;
      r_illegal_p1 <= 1'b0;
      r_instr_p1   <= '0;
      r_ext_pend   <= 1'b0;
      r_ext_q      <= '0;
    end else if (bus.flush) begin
      // Flush wins over any same-cycle accept; held fields are simply invalidated.
      r_vld_p1   <= 1'b0;
      r_ext_pend <= 1'b0;
    end else if (w_accept) begin
      if (w_is_ext) begin
        // Prefix produces nothing, but the held output may still drain.
        r_ext_q    <= EXTW'(bus.instr[3:0]);
        r_ext_pend <= 1'b1;
        r_vld_p1   <= r_vld_p1 && !bus.out_ready;
      end else begin
        r_vld_p1     <= 1'b1;
        r_reg0_p1    <= w_dec.reg0[RW-1:0];
        r_reg1_p1    <= w_dec.reg1[RW-1:0];
        r_imm_p1     <= w_dec.imm[IMMW-1:0];
        r_use_imm_p1 <= w_dec.use_imm;
        r_illegal_p1 <= w_dec.illegal;
        r_instr_p1   <= bus.instr;
        r_ext_pend   <= 1'b0;
      end
    end else if (bus.out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld_p1;
  assign bus.reg0      = r_reg0_p1;
  assign bus.reg1      = r_reg1_p1;
  assign bus.imm       = r_imm_p1;
  assign bus.use_imm   = r_use_imm_p1;
  assign bus.illegal   = r_illegal_p1;
  assign bus.instr_q   = r_instr_p1;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  typedef struct packed {
    logic [3:0] reg0;
    logic [3:0] reg1;
    logic [7:0] imm;
    logic       use_imm;
    logic       illegal;
    logic [8:0] iq;
  } exp_t;

  logic clk;
  logic rst_n;

  decode_if #(.IW(9), .RW(4), .IMMW(8)) bus ();

  decode_stage #(.IW(9), .RW(4), .IMMW(8), .LDI_BASE(8'h40)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  logic m_ov   = 1'b0;
  logic m_pend = 1'b0;
  logic [3:0] m_ext = 4'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode written straight from the opcode table.
  function automatic exp_t predict(input logic [8:0] ins, input logic pend, input logic [3:0] ext);
    exp_t e;
    logic [4:0] c;
    logic [3:0] x;
    e = '0;
    e.iq = ins;
    c = ins[8:4];
    x = pend ? ext : 4'h0;
    if (c[4:3] == 2'b00) begin
      e.reg0 = {1'b0, ins[5:3]};
      e.reg1 = {1'b0, ins[2:0]};
    end else if (c[4:3] == 2'b01) begin
      e.reg0 = {2'b00, ins[3:2]};
      e.reg1 = {2'b00, ins[1:0]};
    end else if (c == 5'b10000 || c == 5'b10001 || c == 5'b10010) begin
      e.imm = {x, ins[3:0]};
      e.use_imm = 1'b1;
    end else if (c >= 5'b10100 && c <= 5'b10111) begin
      e.reg0 = {1'b0, ins[2:0]};
    end else if (c == 5'b11000) begin
      e.imm = pend ? {ext, ins[3:0]} : (8'h40 | {4'h0, ins[3:0]});
      e.use_imm = 1'b1;
    end else begin
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step(input logic v, input logic [8:0] ins, input logic ordy, input logic fl);
    logic m_ready;
    logic acc;
    exp_t e;
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    m_ready = !m_ov || ordy;
    chk("in_ready", 32'(bus.in_ready), 32'(m_ready));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q[0];
        chk("reg0", 32'(bus.reg0), 32'(e.reg0));
        chk("reg1", 32'(bus.reg1), 32'(e.reg1));
        chk("imm", 32'(bus.imm), 32'(e.imm));
        chk("use_imm", 32'(bus.use_imm), 32'(e.use_imm));
        chk("illegal", 32'(bus.illegal), 32'(e.illegal));
        chk("instr_q", 32'(bus.instr_q), 32'(e.iq));
        if (ordy || fl) void'(q.pop_front());
      end
    end
    acc = v && m_ready;
    if (fl) begin
      m_ov = 1'b0;
      m_pend = 1'b0;
    end else if (acc && ins[8:4] == 5'b11001) begin
      m_ext = ins[3:0];
      m_pend = 1'b1;
      m_ov = m_ov && !ordy;
    end else if (acc) begin
      q.push_back(predict(ins, m_pend, m_ext));
      m_ov = 1'b1;
      m_pend = 1'b0;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.instr = '0;
    bus.out_ready = 1'b0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_imm", 32'(bus.imm), 32'd0);
    chk("rst_instr_q", 32'(bus.instr_q), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #2;

    // RR3 decode
    step(1'b1, 9'h02B, 1'b1, 1'b0);
    chk("rr3_valid", 32'(bus.out_valid), 32'd1);
    chk("rr3_reg0", 32'(bus.reg0), 32'd5);
    chk("rr3_reg1", 32'(bus.reg1), 32'd3);
    chk("rr3_use_imm", 32'(bus.use_imm), 32'd0);

    // ldi without, with, and again without prefix
    step(1'b1, 9'h185, 1'b1, 1'b0);
    chk("ldi_imm", 32'(bus.imm), 32'h45);
    chk("ldi_use_imm", 32'(bus.use_imm), 32'd1);
    step(1'b1, 9'h193, 1'b1, 1'b0);
    chk("pfx_no_output", 32'(bus.out_valid), 32'd0);
    step(1'b1, 9'h185, 1'b1, 1'b0);
    chk("ldi_pfx_imm", 32'(bus.imm), 32'h35);
    step(1'b1, 9'h185, 1'b1, 1'b0);
    chk("ldi_after_pfx_imm", 32'(bus.imm), 32'h45);

    // prefix then jump; prefix consumed by a register op
    step(1'b1, 9'h193, 1'b1, 1'b0);
    step(1'b1, 9'h12A, 1'b1, 1'b0);
    chk("jmp_pfx_imm", 32'(bus.imm), 32'h3A);
    step(1'b1, 9'h193, 1'b1, 1'b0);
    step(1'b1, 9'h02B, 1'b1, 1'b0);
    step(1'b1, 9'h185, 1'b1, 1'b0);
    chk("pfx_cleared_imm", 32'(bus.imm), 32'h45);
    // back-to-back prefixes overwrite
    step(1'b1, 9'h197, 1'b1, 1'b0);
    step(1'b1, 9'h192, 1'b1, 1'b0);
    step(1'b1, 9'h101, 1'b1, 1'b0);
    chk("pfx_overwrite_imm", 32'(bus.imm), 32'h21);

    // backpressure
    step(1'b1, 9'h0C6, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 9'h0A1, 1'b0, 1'b0);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_hold_reg0", 32'(bus.reg0), 32'd1);
      chk("bp_hold_reg1", 32'(bus.reg1), 32'd2);
    end
    step(1'b1, 9'h0A1, 1'b1, 1'b0);
    chk("bp_next_instr_q", 32'(bus.instr_q), 32'h0A1);
    step(1'b0, 9'h000, 1'b1, 1'b0);

    // flush with accept and prefix pending
    step(1'b1, 9'h193, 1'b1, 1'b0);
    step(1'b1, 9'h12A, 1'b1, 1'b1);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    step(1'b1, 9'h185, 1'b1, 1'b0);
    chk("flush_ldi_imm", 32'(bus.imm), 32'h45);
    // flush of a stalled held output
    step(1'b1, 9'h02B, 1'b1, 1'b0);
    step(1'b0, 9'h000, 1'b0, 1'b1);
    chk("flush_held_valid", 32'(bus.out_valid), 32'd0);

    // illegal and R1
    step(1'b1, 9'h1F0, 1'b1, 1'b0);
    chk("ill_flag", 32'(bus.illegal), 32'd1);
    chk("ill_reg0", 32'(bus.reg0), 32'd0);
    chk("ill_reg1", 32'(bus.reg1), 32'd0);
    chk("ill_imm", 32'(bus.imm), 32'd0);
    step(1'b1, 9'h130, 1'b1, 1'b0);
    chk("ill_10011", 32'(bus.illegal), 32'd1);
    step(1'b1, 9'h14D, 1'b1, 1'b0);
    chk("r1_reg0", 32'(bus.reg0), 32'd5);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 9'($urandom_range(0, 511)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end

    // reset mid-operation with a prefix pending
    step(1'b1, 9'h02B, 1'b1, 1'b0);
    step(1'b1, 9'h193, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_reg0", 32'(bus.reg0), 32'd0);
    chk("arst_instr_q", 32'(bus.instr_q), 32'd0);
    q.delete();
    m_ov = 1'b0;
    m_pend = 1'b0;
    m_ext = 4'h0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #2;
    step(1'b1, 9'h185, 1'b1, 1'b0);
    chk("arst_pfx_lost_imm", 32'(bus.imm), 32'h45);
    step(1'b0, 9'h000, 1'b1, 1'b0);
    step(1'b0, 9'h000, 1'b1, 1'b0);
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
